shift_unit_pipelined: RTL and testbench

- Parametrised, pipelined successor to the combinational 8-bit LSL/LSR/ASR barrel shifters in the CPU datapath.
- Handles WIDTH-bit operands and four modes: LSL, LSR, ASR and ROR (rotate right).
- Registers each log2(WIDTH) mux column, and produces a carry-out flag and a zero flag.
- Sits between the register-file read stage and ALU writeback, using a valid/ready handshake so the ALU can stall it.

---
 rtl/shift_unit_pipelined.sv | 144 ++++++++++++++
 tb/tb_shift_unit_pipelined.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit_pipelined.sv
// shift_unit_pipelined
//   Pipelined WIDTH-bit shifter/rotator (LSL, LSR, ASR, ROR) with carry-out and
//   zero flags. One register stage per shift-amount bit; stage k applies a shift
//   of 2^k when its amount bit is set. A valid/ready handshake lets the consumer
//   stall the whole pipe.
//
// Ports
//   CLK          in   rising-edge clock
//   RESET_N      in   asynchronous active-low reset
//   IN_VALID     in   OPERAND/SHIFT_AMOUNT/OPCODE valid
//   IN_READY     out  unit can accept an input this cycle
//   OPERAND      in   [WIDTH]   data to shift
//   SHIFT_AMOUNT in   [SHAMT_W] shift distance 0..WIDTH-1
//   OPCODE       in   [2]  00=LSL 01=LSR 10=ASR 11=ROR
//   OUT_VALID    out  RESULT/flags valid
//   OUT_READY    in   consumer accepts output this cycle
//   RESULT       out  [WIDTH] shifted/rotated value
//   CARRY_OUT    out  last bit shifted out (ROR: result MSB), 0 for amount 0
//   ZERO         out  RESULT == 0 (ungated; qualify with OUT_VALID)

module shift_unit_pipelined #(
    parameter  int WIDTH   = 8,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [WIDTH-1:0]   OPERAND,
    input  logic [SHAMT_W-1:0] SHIFT_AMOUNT,
    input  logic [1:0]         OPCODE,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [WIDTH-1:0]   RESULT,
    output logic               CARRY_OUT,
    output logic               ZERO
);

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;

    if ((WIDTH < 4) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_width_check
        $error("shift_unit_pipelined: WIDTH must be a power of two and at least 4");
    end

    // Whole pipe moves together; it only freezes when a result is waiting
    // and the consumer is not taking it.
    logic advance;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int N = 1 << k;

        logic [WIDTH-1:0]   d_in;
        logic [WIDTH-1:0]   d_sh;
        logic [SHAMT_W-1:0] a_in;
        logic [1:0]         o_in;
        logic               s_in;
        logic               c_in;
        logic               v_in;
        logic               c_sh;

        logic [WIDTH-1:0]   data_q;
        logic [SHAMT_W-1:0] amt_q;
        logic [1:0]         opc_q;
        logic               sign_q;
        logic               carry_q;
        logic               valid_q;

        if (k == 0) begin : g_src
            // Sign is captured once at entry so ASR fills stay correct after
            // earlier stages have already moved the MSB.
            assign d_in = OPERAND;
            assign a_in = SHIFT_AMOUNT;
            assign o_in = OPCODE;
            assign s_in = OPERAND[WIDTH-1];
            assign c_in = 1'b0;
            assign v_in = IN_VALID;
        end else begin : g_src
            assign d_in = g_stage[k-1].data_q;
            assign a_in = g_stage[k-1].amt_q;
            assign o_in = g_stage[k-1].opc_q;
            assign s_in = g_stage[k-1].sign_q;
            assign c_in = g_stage[k-1].carry_q;
            assign v_in = g_stage[k-1].valid_q;
        end

        // Carry is the last bit moved out; for ROR that bit lands in the MSB.
        always_comb begin
            d_sh = d_in;
            c_sh = 1'b0;
            case (o_in)
                OP_LSL: begin
                    d_sh = d_in << N;
                    c_sh = d_in[WIDTH-N];
                end
                OP_LSR: begin
                    d_sh = d_in >> N;
                    c_sh = d_in[N-1];
                end
                OP_ASR: begin
                    d_sh = (d_in >> N) | ({WIDTH{s_in}} << (WIDTH - N));
                    c_sh = d_in[N-1];
                end
                default: begin
                    d_sh = (d_in >> N) | (d_in << (WIDTH - N));
                    c_sh = d_in[N-1];
                end
            endcase
        end

        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                data_q  <= '0;
                amt_q   <= '0;
                opc_q   <= '0;
                sign_q  <= 1'b0;
                carry_q <= 1'b0;
                valid_q <= 1'b0;
            end else if (advance) begin
                data_q  <= a_in[k] ? d_sh : d_in;
                carry_q <= a_in[k] ? c_sh : c_in;
                amt_q   <= a_in;
                opc_q   <= o_in;
                sign_q  <= s_in;
                valid_q <= v_in;
            end
        end
    end

    assign OUT_VALID = g_stage[SHAMT_W-1].valid_q;
    assign RESULT    = g_stage[SHAMT_W-1].data_q;
    assign CARRY_OUT = g_stage[SHAMT_W-1].carry_q;
    assign ZERO      = ~|RESULT;

    assign advance  = !OUT_VALID || OUT_READY;
    assign IN_READY = advance;

    // Control fields of the last stage have no consumer; synthesis drops them.
    logic unused_tail;
    assign unused_tail = ^{g_stage[SHAMT_W-1].amt_q, g_stage[SHAMT_W-1].opc_q,
                           g_stage[SHAMT_W-1].sign_q};

endmodule

// File: tb/tb_shift_unit_pipelined.sv
module tb_shift_unit_pipelined;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        v8 = 1'b0, ir8, ov8, ordy8 = 1'b0, co8, z8;
    logic [7:0]  op8 = '0, res8;
    logic [2:0]  amt8 = '0;
    logic [1:0]  opc8 = '0;

    logic        v16 = 1'b0, ir16, ov16, ordy16 = 1'b0, co16, z16;
    logic [15:0] op16 = '0, res16;
    logic [3:0]  amt16 = '0;
    logic [1:0]  opc16 = '0;

    int vectors = 0;
    int miscompares = 0;

    logic [33:0] q8[$];
    logic [33:0] q16[$];
    int pops8 = 0, pops16 = 0, acc16 = 0;
    logic hold8 = 1'b0, hold16 = 1'b0;
    logic [33:0] held8, held16;

    always #5 clk = ~clk;

    shift_unit_pipelined #(.WIDTH(8)) u8 (
        .CLK(clk), .RESET_N(rst_n), .IN_VALID(v8), .IN_READY(ir8),
        .OPERAND(op8), .SHIFT_AMOUNT(amt8), .OPCODE(opc8),
        .OUT_VALID(ov8), .OUT_READY(ordy8), .RESULT(res8),
        .CARRY_OUT(co8), .ZERO(z8)
    );

    shift_unit_pipelined #(.WIDTH(16)) u16 (
        .CLK(clk), .RESET_N(rst_n), .IN_VALID(v16), .IN_READY(ir16),
        .OPERAND(op16), .SHIFT_AMOUNT(amt16), .OPCODE(opc16),
        .OUT_VALID(ov16), .OUT_READY(ordy16), .RESULT(res16),
        .CARRY_OUT(co16), .ZERO(z16)
    );

    // Reference: whole-word arithmetic on the shift rules, {zero, carry, result}.
    function automatic logic [33:0] ref_exp(input int w, input logic [31:0] x,
                                            input int s, input logic [1:0] opc);
        logic [31:0] m, r;
        logic c;
        m = (32'h1 << w) - 32'h1;
        x = x & m;
        case (opc)
            2'd0:    r = (x << s) & m;
            2'd1:    r = x >> s;
            2'd2:    r = (x >> s) | (x[w-1] ? (m & ~(m >> s)) : 32'h0);
            default: r = (s == 0) ? x : (((x >> s) | (x << (w - s))) & m);
        endcase
        if (s == 0)        c = 1'b0;
        else if (opc == 0) c = x[w-s];
        else if (opc == 3) c = r[w-1];
        else               c = x[s-1];
        return {(r == 32'h0), c, r};
    endfunction

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle on the 8-bit unit: drive after negedge, sample, then advance.
    task automatic step8(input logic iv, input logic [7:0] x, input logic [2:0] s,
                         input logic [1:0] opc, input logic ordy);
        logic [33:0] obs;
        v8 = iv; op8 = x; amt8 = s; opc8 = opc; ordy8 = ordy;
        #1;
        obs = {z8, co8, 24'h0, res8};
        if (ov8 && hold8) chk("hold8", obs, held8);
        if (ov8 && ordy8) begin
            chk("nonempty8", 34'(q8.size() != 0), 34'd1);
            if (q8.size() != 0) chk("out8", obs, q8.pop_front());
            pops8++;
        end
        if (v8 && ir8) q8.push_back(ref_exp(8, 32'(x), int'(s), opc));
        hold8 = ov8 && !ordy8;
        held8 = obs;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step16(input logic iv, input logic [15:0] x, input logic [3:0] s,
                          input logic [1:0] opc, input logic ordy);
        logic [33:0] obs;
        v16 = iv; op16 = x; amt16 = s; opc16 = opc; ordy16 = ordy;
        #1;
        obs = {z16, co16, 16'h0, res16};
        if (ov16 && hold16) chk("hold16", obs, held16);
        if (ov16 && ordy16) begin
            chk("nonempty16", 34'(q16.size() != 0), 34'd1);
            if (q16.size() != 0) chk("out16", obs, q16.pop_front());
            pops16++;
        end
        if (v16 && ir16) begin
            q16.push_back(ref_exp(16, 32'(x), int'(s), opc));
            acc16++;
        end
        hold16 = ov16 && !ordy16;
        held16 = obs;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int p0;
        int cyc;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_ov8", 34'(ov8), 34'd0);
        chk("rst_res8", 34'(res8), 34'd0);
        chk("rst_co8", 34'(co8), 34'd0);
        chk("rst_ov16", 34'(ov16), 34'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ir8", 34'(ir8), 34'd1);
        @(negedge clk);

        // Latency: 0xB5 LSL 3
        step8(1'b1, 8'hB5, 3'd3, 2'd0, 1'b1);
        chk("lat_ov_e0", 34'(ov8), 34'd0);
        step8(1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
        chk("lat_ov_e1", 34'(ov8), 34'd0);
        step8(1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
        chk("lat_ov_e2", 34'(ov8), 34'd1);
        chk("lat_res", {z8, co8, 24'h0, res8}, {1'b0, 1'b1, 32'h0000_00A8});
        step8(1'b0, 8'h00, 3'd0, 2'd0, 1'b1);

        // Back-to-back, one result per cycle
        p0 = pops8;
        step8(1'b1, 8'hB5, 3'd2, 2'd1, 1'b1);
        step8(1'b1, 8'hB5, 3'd2, 2'd2, 1'b1);
        step8(1'b1, 8'hB5, 3'd2, 2'd3, 1'b1);
        step8(1'b1, 8'h80, 3'd7, 2'd1, 1'b1);
        step8(1'b1, 8'h01, 3'd0, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) step8(1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
        chk("b2b_pops", 34'(pops8 - p0), 34'd5);

        // Backpressure: 5 stalled cycles once the first result shows
        p0 = pops8;
        step8(1'b1, 8'hC3, 3'd1, 2'd0, 1'b1);
        step8(1'b1, 8'h5A, 3'd4, 2'd3, 1'b1);
        step8(1'b1, 8'hF0, 3'd5, 2'd2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step8(1'b1, 8'h96, 3'd6, 2'd1, 1'b0);
            chk("stall_ir", 34'(ir8), 34'd0);
        end
        step8(1'b1, 8'h96, 3'd6, 2'd1, 1'b1);
        for (int i = 0; i < 5; i++) step8(1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
        chk("bp_pops", 34'(pops8 - p0), 34'd4);
        chk("bp_empty", 34'(q8.size()), 34'd0);

        // Zero / carry edges
        step8(1'b1, 8'h01, 3'd1, 2'd1, 1'b0);
        step8(1'b0, 8'h00, 3'd0, 2'd0, 1'b0);
        step8(1'b0, 8'h00, 3'd0, 2'd0, 1'b0);
        chk("zero_lsr", {ov8, z8, co8, 23'h0, res8}, {1'b1, 1'b1, 1'b1, 31'h0});
        step8(1'b1, 8'h80, 3'd7, 2'd2, 1'b1);
        for (int i = 0; i < 3; i++) step8(1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
        chk("zc_empty", 34'(q8.size()), 34'd0);

        // Reset with items in flight
        step8(1'b1, 8'hA5, 3'd1, 2'd0, 1'b0);
        step8(1'b1, 8'h3C, 3'd5, 2'd3, 1'b0);
        step8(1'b1, 8'h7F, 3'd2, 2'd2, 1'b0);
        chk("pre_rst_ov", 34'(ov8), 34'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ov", 34'(ov8), 34'd0);
        chk("midrst_res", 34'(res8), 34'd0);
        q8.delete();
        hold8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step8(1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
            chk("no_stale", 34'(ov8), 34'd0);
        end
        step8(1'b1, 8'hC3, 3'd4, 2'd1, 1'b1);
        chk("post_e0", 34'(ov8), 34'd0);
        step8(1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
        chk("post_e1", 34'(ov8), 34'd0);
        step8(1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
        chk("post_e2", 34'(ov8), 34'd1);
        step8(1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
        chk("post_empty", 34'(q8.size()), 34'd0);

        // 16-bit: 0x8001 ROR 4, four-cycle latency
        step16(1'b1, 16'h8001, 4'd4, 2'd3, 1'b1);
        chk("w16_e0", 34'(ov16), 34'd0);
        step16(1'b0, 16'h0, 4'd0, 2'd0, 1'b1);
        chk("w16_e1", 34'(ov16), 34'd0);
        step16(1'b0, 16'h0, 4'd0, 2'd0, 1'b1);
        chk("w16_e2", 34'(ov16), 34'd0);
        step16(1'b0, 16'h0, 4'd0, 2'd0, 1'b1);
        chk("w16_ror", {ov16, z16, co16, 15'h0, res16}, {1'b1, 1'b0, 1'b0, 31'h1800});
        step16(1'b0, 16'h0, 4'd0, 2'd0, 1'b1);

        // Random handshaked traffic
        acc16 = 0;
        cyc = 0;
        while (acc16 < 10000 && cyc < 40000) begin
            step16($urandom_range(0, 3) != 0, 16'($urandom), 4'($urandom_range(0, 15)),
                   2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
            cyc++;
        end
        chk("rand_accepted", 34'(acc16), 34'd10000);
        for (int i = 0; i < 8; i++) step16(1'b0, 16'h0, 4'd0, 2'd0, 1'b1);
        chk("rand_drained", 34'(q16.size()), 34'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
